// File: rtl/shift_arbiter.sv
// ============================================================================
//  Module      : shift_arbiter
//  Description : Two-port arbiter sharing one barrel shifter (SLL/SRL/SRA/ROTR)
//                with a single-entry, id-tagged result register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_arbiter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter bit RR    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_rt,
    input  logic [SHW-1:0]   req0_shamt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_rt,
    input  logic [SHW-1:0]   req1_shamt,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_ptr;
    logic [WIDTH-1:0]   r_res_data;
    logic               r_res_id;
    logic [15:0]        r_cnt0;
    logic [15:0]        r_cnt1;

    logic               w_can_accept;
    logic               w_grant;
    logic               w_acc0;
    logic               w_acc1;
    logic               w_accept;
    logic [1:0]         w_op;
    logic [WIDTH-1:0]   w_rt;
    logic [SHW-1:0]     w_sh;
    logic [2*WIDTH-1:0] w_rot;
    logic [WIDTH-1:0]   w_shifted;

    // Pointer only matters on contention; a lone requester always wins.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = RR ? r_ptr : 1'b0;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_can_accept = (r_state == S_EMPTY) || res_ready;
        w_acc0       = rst_n && w_can_accept && req0_valid && !w_grant;
        w_acc1       = rst_n && w_can_accept && req1_valid &&  w_grant;
        w_accept     = w_acc0 || w_acc1;
        case (r_state)
            S_EMPTY: if (w_accept)               w_state_nxt = S_FULL;
            S_FULL:  if (res_ready && !w_accept) w_state_nxt = S_EMPTY;
            default:                             w_state_nxt = S_EMPTY;
        endcase
    end

    assign w_op  = w_grant ? req1_op    : req0_op;
    assign w_rt  = w_grant ? req1_rt    : req0_rt;
    assign w_sh  = w_grant ? req1_shamt : req0_shamt;
    // Rotate via a doubled operand so shamt=0 needs no special case.
    assign w_rot = {w_rt, w_rt} >> w_sh;

    always_comb begin
        w_shifted = w_rt;
        case (w_op)
            2'b00:   w_shifted = w_rt << w_sh;
            2'b01:   w_shifted = w_rt >> w_sh;
            2'b10:   w_shifted = $signed(w_rt) >>> w_sh;
            default: w_shifted = w_rot[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_ptr      <= 1'b0;
            r_res_data <= '0;
            r_res_id   <= 1'b0;
            r_cnt0     <= 16'd0;
            r_cnt1     <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_res_data <= w_shifted;
                r_res_id   <= w_grant;
                r_ptr      <= ~w_grant;
            end
            if (w_acc0) r_cnt0 <= r_cnt0 + 16'd1;
            if (w_acc1) r_cnt1 <= r_cnt1 + 16'd1;
        end
    end

    assign req0_ready = w_acc0;
    assign req1_ready = w_acc1;
    assign res_valid  = (r_state == S_FULL);
    assign res_data   = r_res_data;
    assign res_id     = r_res_id;
    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// ============================================================================
//  Module      : tb_shift_arbiter
//  Description : Scoreboard bench for shift_arbiter (round-robin instance plus
//                a fixed-priority instance sharing the same stimulus).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid, res_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_rt, req1_rt;
    logic [4:0]  req0_shamt, req1_shamt;

    logic        req0_ready, req1_ready, res_valid, res_id;
    logic [31:0] res_data;
    logic [15:0] grant_cnt0, grant_cnt1;

    logic        fp_req0_ready, fp_req1_ready, fp_res_valid, fp_res_id;
    logic [31:0] fp_res_data;
    logic [15:0] fp_cnt0, fp_cnt1;

    int n_chk  = 0;
    int n_pass = 0;

    shift_arbiter #(.WIDTH(32), .SHW(5), .RR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_rt(req0_rt), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_rt(req1_rt), .req1_shamt(req1_shamt),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    shift_arbiter #(.WIDTH(32), .SHW(5), .RR(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op),
        .req0_rt(req0_rt), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op),
        .req1_rt(req1_rt), .req1_shamt(req1_shamt),
        .res_valid(fp_res_valid), .res_ready(res_ready), .res_data(fp_res_data),
        .res_id(fp_res_id), .grant_cnt0(fp_cnt0), .grant_cnt1(fp_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Bit-by-bit reference shifter.
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] rt,
                                              input logic [4:0] sh);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            int s;
            case (op)
                2'b00: begin s = i - int'(sh); r[i] = (s >= 0) ? rt[s] : 1'b0;  end
                2'b01: begin s = i + int'(sh); r[i] = (s < 32) ? rt[s] : 1'b0;  end
                2'b10: begin s = i + int'(sh); r[i] = (s < 32) ? rt[s] : rt[31]; end
                default: begin s = (i + int'(sh)) % 32; r[i] = rt[s]; end
            endcase
        end
        return r;
    endfunction

    // Scoreboard model of the round-robin instance, evaluated mid-cycle.
    logic [32:0] sb[$];
    logic        m_full = 1'b0;
    logic        m_ptr  = 1'b0;
    logic [15:0] m_c0   = 16'd0;
    logic [15:0] m_c1   = 16'd0;

    always @(negedge clk) begin
        logic g, can, e0, e1;
        if (!rst_n) begin
            check("rst_rdy0", req0_ready, 1'b0);
            check("rst_rdy1", req1_ready, 1'b0);
            m_full = 1'b0;
            m_ptr  = 1'b0;
            m_c0   = 16'd0;
            m_c1   = 16'd0;
            sb.delete();
        end else begin
            can = !m_full || res_ready;
            g   = (req0_valid && req1_valid) ? m_ptr : req1_valid;
            e0  = can && req0_valid && !g;
            e1  = can && req1_valid &&  g;
            check("rdy0", req0_ready, e0);
            check("rdy1", req1_ready, e1);
            check("res_valid", res_valid, m_full);
            check("cnt0", grant_cnt0, m_c0);
            check("cnt1", grant_cnt1, m_c1);
            if (m_full) begin
                if (sb.size() == 0) begin
                    check("sb_nonempty", 1'b0, 1'b1);
                end else begin
                    check("res_data", res_data, sb[0][31:0]);
                    check("res_id", res_id, sb[0][32]);
                    if (res_ready) void'(sb.pop_front());
                end
            end
            if (e0) begin
                sb.push_back({1'b0, ref_shift(req0_op, req0_rt, req0_shamt)});
                m_c0 = m_c0 + 16'd1;
            end
            if (e1) begin
                sb.push_back({1'b1, ref_shift(req1_op, req1_rt, req1_shamt)});
                m_c1 = m_c1 + 16'd1;
            end
            if (e0 || e1) m_ptr = !g;
            m_full = e0 || e1 || (m_full && !res_ready);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rt;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$] = '{
        '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000},
        '{2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000},
        '{2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000},
        '{2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000},
        '{2'b11, 32'h0000_00F1, 5'd4,  32'h1000_000F},
        '{2'b10, 32'h7000_0000, 5'd4,  32'h0700_0000},
        '{2'b00, 32'hA5A5_1234, 5'd0,  32'hA5A5_1234},
        '{2'b01, 32'hA5A5_1234, 5'd0,  32'hA5A5_1234},
        '{2'b10, 32'hA5A5_1234, 5'd0,  32'hA5A5_1234},
        '{2'b11, 32'hA5A5_1234, 5'd0,  32'hA5A5_1234}
    };

    logic exp_id_seq[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rst_n = 1'b0; res_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_rt = 32'h1; req0_shamt = 5'd1;
        req1_valid = 1'b1; req1_op = 2'b01; req1_rt = 32'h100; req1_shamt = 5'd4;

        // T1: reset held with both requesters valid
        step(); step();
        check("t1_rdy0", req0_ready, 1'b0);
        check("t1_rdy1", req1_ready, 1'b0);
        check("t1_valid", res_valid, 1'b0);
        check("t1_cnt0", grant_cnt0, 16'd0);
        check("t1_cnt1", grant_cnt1, 16'd0);
        check("t1_data", res_data, 32'h0);
        req1_valid = 1'b0;
        rst_n = 1'b1;

        // T2: single-port operations, one accept per vector
        foreach (vecs[k]) begin
            req0_valid = 1'b1;
            req0_op = vecs[k].op; req0_rt = vecs[k].rt; req0_shamt = vecs[k].sh;
            step();
            check($sformatf("t2_op%0d", k), res_data, vecs[k].exp);
        end
        req0_valid = 1'b0;
        step();

        // T3: round-robin contention from a fresh pointer
        rst_n = 1'b0; step(); rst_n = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_rt = 32'h3;   req0_shamt = 5'd2;
        req1_valid = 1'b1; req1_op = 2'b01; req1_rt = 32'h100; req1_shamt = 5'd4;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("t3_id%0d", i), res_id, exp_id_seq[i]);
            check($sformatf("t3_data%0d", i), res_data, exp_id_seq[i] ? 32'h10 : 32'hC);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("t3_cnt0", grant_cnt0, 16'd2);
        check("t3_cnt1", grant_cnt1, 16'd2);
        step();

        // T4: backpressure, then drain and accept in the same cycle
        req0_valid = 1'b1; req0_op = 2'b10; req0_rt = 32'h8000_0F00; req0_shamt = 5'd8;
        step();
        req0_valid = 1'b0; res_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 2'b11; req1_rt = 32'h0000_00F1; req1_shamt = 5'd4;
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_data", res_data, 32'hFF80_000F);
            check("t4_stall_id", res_id, 1'b0);
            check("t4_stall_rdy1", req1_ready, 1'b0);
            step();
        end
        res_ready = 1'b1;
        #1;
        check("t4_drain_rdy1", req1_ready, 1'b1);
        step();
        req1_valid = 1'b0;
        check("t4_new_valid", res_valid, 1'b1);
        check("t4_new_id", res_id, 1'b1);
        check("t4_new_data", res_data, 32'h1000_000F);
        step();

        // T5: fixed-priority instance starves port 1 while port 0 stays valid
        rst_n = 1'b0; step(); rst_n = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_rt = 32'h1; req0_shamt = 5'd3;
        req1_valid = 1'b1; req1_op = 2'b01; req1_rt = 32'hF0; req1_shamt = 5'd4;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("t5_fp_rdy0", fp_req0_ready, 1'b1);
            check("t5_fp_rdy1", fp_req1_ready, 1'b0);
            step();
            check("t5_fp_id", fp_res_id, 1'b0);
        end
        check("t5_fp_cnt1", fp_cnt1, 16'd0);
        req0_valid = 1'b0;
        #1;
        check("t5_fp_rdy1_free", fp_req1_ready, 1'b1);
        step();
        req1_valid = 1'b0;
        check("t5_fp_id1", fp_res_id, 1'b1);
        check("t5_fp_data1", fp_res_data, 32'h0000_000F);
        step();

        // T6: reset while the output register is full
        req0_valid = 1'b1; req0_op = 2'b00; req0_rt = 32'h5; req0_shamt = 5'd1;
        step();
        req0_valid = 1'b0; res_ready = 1'b0;
        step();
        check("t6_full", res_valid, 1'b1);
        rst_n = 1'b0; res_ready = 1'b1; req0_valid = 1'b1;
        step();
        check("t6_valid", res_valid, 1'b0);
        check("t6_cnt0", grant_cnt0, 16'd0);
        check("t6_data", res_data, 32'h0);
        rst_n = 1'b1; req0_valid = 1'b0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
